test_run_ctrl: RTL and testbench
================================

Name: test_run_ctrl

Overview:
Synthesizable run controller for executing one riscv-tests program on Core.
- Streams a program image into Core's instruction/data memory through a write port.
- Holds Core in reset during load, then releases it.
- Watches Core's pc for the test end address and samples gp (x3) for the result.
- Reports pass/fail/timeout and the run cycle count; sits between the host/loader and Core.

Parameters:
ADDR_W, 16, word-address width of the memory write port
END_PC, 32'h44, pc value that marks test completion
TIMEOUT, 5000, max RUN cycles before declaring timeout (>=1)
RST_CYCLES, 2, cycles Core reset is held after load (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-low reset
start  in  1  begin a new load+run; accepted only in IDLE or DONE
ld_valid  in  1  loader word valid
ld_ready  out  1  controller accepts loader word
ld_addr  in  ADDR_W  word address of loader word
ld_data  in  32  loader word data
ld_last  in  1  final word of image (qualified by ld_valid)
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  32  memory write data
core_rst  out  1  active-high reset to Core
core_pc  in  32  Core program counter
core_gp  in  32  Core register x3
busy  out  1  high in LOAD, CORE_RST, RUN
done  out  1  high in DONE
pass  out  1  result valid when done
timeout  out  1  run ended by timeout, valid when done
cycles  out  32  RUN cycles counted in last/current run

Behaviour:
- Reset (rst==0 at rising edge): state=IDLE, core_rst=1, ld_ready=0, mem_we=0, done=0, pass=0, timeout=0, cycles=0, internal counters=0. Reset mid-load or mid-run aborts immediately; no further writes.
- States: IDLE, LOAD, CORE_RST, RUN, DONE. Encoding free.
- IDLE: core_rst=1. start=1 -> LOAD; clear pass, timeout, cycles.
- LOAD: ld_ready=1, core_rst=1.
  - Write handshake is combinational: mem_we = ld_valid & ld_ready, mem_addr=ld_addr, mem_wdata=ld_data, same cycle.
  - Handshake with ld_last=1 -> CORE_RST next cycle. ld_ready=0 from that cycle on.
  - ld_valid=0 stalls indefinitely. start is ignored.
- CORE_RST: core_rst=1 for exactly RST_CYCLES cycles (down-counter), then RUN.
- RUN: core_rst=0; cycles increments by 1 each RUN cycle, counting the first RUN cycle as 1. Each cycle, evaluated in this order:
  - (a) core_pc==END_PC -> DONE; pass=(core_gp==32'd1); timeout=0.
  - (b) else if cycles==TIMEOUT (the TIMEOUT-th RUN cycle) -> DONE; pass=0; timeout=1.
  - (c) A pc match and the timeout limit in the same cycle resolve as pass/fail; no timeout is reported.
  - cycles holds its final value on exit and saturates at 32'hFFFFFFFF.
- DONE: done=1, core_rst=1 (Core frozen). pass, timeout and cycles are held stable. start=1 -> LOAD with results cleared; done drops the next cycle.
- mem_we=0 and mem_addr/mem_wdata are don't-care outside LOAD.
- pass, timeout and cycles are registered outputs; done and busy decode directly from state.
- No address range check: ld_addr wraps naturally at ADDR_W bits.

Test Plan:
- Load 4 words (addr 0..3, data 0xA0..0xA3, last on word 3), ld_valid always 1 -> mem_we high exactly 4 cycles, addresses 0,1,2,3 in order; core_rst high 2 cycles after last, then low.
- Loader gaps: ld_valid toggles 1,0,0,1 -> mem_we only on valid cycles, state stays LOAD; no CORE_RST until ld_last handshake.
- RUN with core_pc driven to 0x44 on 10th RUN cycle, core_gp=1 -> done=1, pass=1, timeout=0, cycles=10, core_rst=1.
- Same scenario with core_gp=5 -> done=1, pass=0, timeout=0.
- core_pc never 0x44, TIMEOUT=20 -> done on 20th RUN cycle, timeout=1, pass=0, cycles=20. With core_pc=0x44 on cycle 20 and core_gp=1 -> pass=1, timeout=0.
- rst=0 during LOAD after 2 writes -> next cycle IDLE, mem_we=0, core_rst=1, all status 0. start in DONE -> LOAD, done=0 and cycles=0 next cycle.

Source files
------------

// File: rtl/test_run_ctrl.sv
// Run controller for one riscv-tests program: streams the image into Core memory,
// releases Core from reset, then watches pc/gp to report pass, fail or timeout.
module test_run_ctrl #(
  parameter int          ADDR_W     = 16,
  parameter logic [31:0] END_PC     = 32'h44,
  parameter int          TIMEOUT    = 5000,
  parameter int          RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  input  logic [31:0]       core_pc,
  input  logic [31:0]       core_gp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [31:0]       cycles,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_CORE_RST = 3'd2,
    S_RUN      = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);
  localparam logic [31:0] RST_W     = 32'(RST_CYCLES);

  state_t      state;
  logic [31:0] rst_cnt;
  logic [31:0] cyc_next;

  // Loader handshake: valid/ready, a word transfers in any cycle where both are high,
  // and the memory write happens in that same cycle.
  assign ld_ready  = (state == S_LOAD);
  assign mem_we    = ld_valid & ld_ready;
  assign mem_addr  = ld_addr;
  assign mem_wdata = ld_data;

  assign core_rst  = (state != S_RUN);
  assign busy      = (state == S_LOAD) || (state == S_CORE_RST) || (state == S_RUN);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  assign cyc_next  = (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      rst_cnt <= 32'd0;
      pass    <= 1'b0;
      timeout <= 1'b0;
      cycles  <= 32'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_LOAD;
            pass    <= 1'b0;
            timeout <= 1'b0;
            cycles  <= 32'd0;
          end
        end
        S_LOAD: begin
          if (ld_valid && ld_last) begin
            state   <= S_CORE_RST;
            rst_cnt <= RST_W;
          end
        end
        S_CORE_RST: begin
          if (rst_cnt <= 32'd1) begin
            state   <= S_RUN;
            rst_cnt <= 32'd0;
          end else begin
            rst_cnt <= rst_cnt - 32'd1;
          end
        end
        S_RUN: begin
          cycles <= cyc_next;
          // A pc match wins over the timeout limit in the same cycle.
          if (core_pc == END_PC) begin
            state   <= S_DONE;
            pass    <= (core_gp == 32'd1);
            timeout <= 1'b0;
          end else if (cyc_next == TIMEOUT_W) begin
            state   <= S_DONE;
            pass    <= 1'b0;
            timeout <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_test_run_ctrl.sv
// Directed bench for test_run_ctrl: load, gapped load, pass/fail/timeout runs and reset abort.
module tb_test_run_ctrl;

  localparam int ADDR_W = 16;

  localparam logic [31:0] ST_IDLE = 32'd0;
  localparam logic [31:0] ST_LOAD = 32'd1;
  localparam logic [31:0] ST_CRST = 32'd2;
  localparam logic [31:0] ST_RUN  = 32'd3;
  localparam logic [31:0] ST_DONE = 32'd4;

  logic              clk;
  logic              rst;
  logic              start;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic              ld_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst;
  logic [31:0]       core_pc;
  logic [31:0]       core_gp;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [31:0]       cycles;
  logic [2:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  test_run_ctrl #(
    .ADDR_W(ADDR_W), .END_PC(32'h44), .TIMEOUT(20), .RST_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_last(ld_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst(core_rst), .core_pc(core_pc), .core_gp(core_gp),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .cycles(cycles), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one loader word, checks the same-cycle write, then clocks it in.
  task automatic load_word(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    ld_last  = last;
    #1;
    chk("ld_we", 32'(mem_we), 32'd1);
    chk("ld_addr", 32'(mem_addr), 32'(a));
    chk("ld_wdata", mem_wdata, d);
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic check_done(input string tag, input logic p, input logic t, input logic [31:0] c);
    chk({tag, "_state"}, 32'(dbg_state), ST_DONE);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_pass"}, 32'(pass), 32'(p));
    chk({tag, "_timeout"}, 32'(timeout), 32'(t));
    chk({tag, "_cycles"}, cycles, c);
    chk({tag, "_core_rst"}, 32'(core_rst), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    ld_last = 1'b0; core_pc = 32'd0; core_gp = 32'd0;
    tick(); tick();

    // Reset state; a valid word in IDLE must not write.
    ld_valid = 1'b1;
    #1;
    chk("rst_state", 32'(dbg_state), ST_IDLE);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_cycles", cycles, 32'd0);
    ld_valid = 1'b0;

    // Run 1: contiguous 4-word load, pass at 10th RUN cycle.
    rst = 1'b1;
    tick();
    chk("idle_hold", 32'(dbg_state), ST_IDLE);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("r1_load", 32'(dbg_state), ST_LOAD);
    chk("r1_ld_ready", 32'(ld_ready), 32'd1);
    chk("r1_busy", 32'(busy), 32'd1);
    chk("r1_core_rst_load", 32'(core_rst), 32'd1);
    for (int i = 0; i < 4; i++) load_word(ADDR_W'(i), 32'hA0 + 32'(i), i == 3);
    ld_valid = 1'b1;
    #1;
    chk("r1_crst1_state", 32'(dbg_state), ST_CRST);
    chk("r1_crst1_ready", 32'(ld_ready), 32'd0);
    chk("r1_crst1_we", 32'(mem_we), 32'd0);
    chk("r1_crst1_core_rst", 32'(core_rst), 32'd1);
    ld_valid = 1'b0;
    tick();
    chk("r1_crst2_core_rst", 32'(core_rst), 32'd1);
    tick();
    chk("r1_run_state", 32'(dbg_state), ST_RUN);
    chk("r1_run_core_rst", 32'(core_rst), 32'd0);
    core_gp = 32'd1;
    repeat (9) tick();
    chk("r1_run9_state", 32'(dbg_state), ST_RUN);
    chk("r1_run9_cycles", cycles, 32'd9);
    core_pc = 32'h44;
    tick();
    core_pc = 32'd0;
    check_done("r1", 1'b1, 1'b0, 32'd10);
    tick(); tick();
    chk("r1_hold_pass", 32'(pass), 32'd1);
    chk("r1_hold_cycles", cycles, 32'd10);

    // Run 2: restart from DONE, gapped load (1,0,0,1), fail with gp=5.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("r2_load", 32'(dbg_state), ST_LOAD);
    chk("r2_done_drop", 32'(done), 32'd0);
    chk("r2_cycles_clr", cycles, 32'd0);
    chk("r2_pass_clr", 32'(pass), 32'd0);
    load_word(16'd10, 32'h1234_5678, 1'b0);
    ld_last = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("r2_gap_we", 32'(mem_we), 32'd0);
      tick();
      chk("r2_gap_state", 32'(dbg_state), ST_LOAD);
    end
    load_word(16'hFFFF, 32'hDEAD_BEEF, 1'b1);
    chk("r2_crst", 32'(dbg_state), ST_CRST);
    tick(); tick();
    chk("r2_run", 32'(dbg_state), ST_RUN);
    core_gp = 32'd5;
    repeat (9) tick();
    core_pc = 32'h44;
    tick();
    core_pc = 32'd0;
    check_done("r2", 1'b0, 1'b0, 32'd10);

    // Run 3: pc never reaches END_PC -> timeout on 20th RUN cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    load_word(16'd0, 32'h0, 1'b1);
    tick(); tick();
    chk("r3_run", 32'(dbg_state), ST_RUN);
    core_gp = 32'd1;
    repeat (19) tick();
    chk("r3_run19_state", 32'(dbg_state), ST_RUN);
    chk("r3_run19_cycles", cycles, 32'd19);
    tick();
    check_done("r3", 1'b0, 1'b1, 32'd20);

    // Run 4: pc match on the 20th cycle beats the timeout.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("r4_timeout_clr", 32'(timeout), 32'd0);
    load_word(16'd0, 32'h0, 1'b1);
    tick(); tick();
    repeat (19) tick();
    core_pc = 32'h44;
    tick();
    core_pc = 32'd0;
    check_done("r4", 1'b1, 1'b0, 32'd20);

    // Reset during LOAD after two writes aborts straight to IDLE.
    start = 1'b1;
    tick();
    start = 1'b0;
    load_word(16'd0, 32'h11, 1'b0);
    load_word(16'd1, 32'h22, 1'b0);
    chk("abort_pre", 32'(dbg_state), ST_LOAD);
    rst = 1'b0;
    ld_valid = 1'b1;
    tick();
    chk("abort_state", 32'(dbg_state), ST_IDLE);
    chk("abort_we", 32'(mem_we), 32'd0);
    chk("abort_core_rst", 32'(core_rst), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_pass", 32'(pass), 32'd0);
    chk("abort_timeout", 32'(timeout), 32'd0);
    chk("abort_cycles", cycles, 32'd0);
    ld_valid = 1'b0;
    rst = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
